// File: rtl/wvb_reader_pkg.sv
// ---------------------------------------------------------------------------
// wvb_reader_pkg
// Shared definitions for the waveform-buffer reader and its skid FIFO:
// sample bit positions, frame marker bytes, FSM state encoding and the
// trailer word builder.
// ---------------------------------------------------------------------------
package wvb_reader_pkg;

    // Sample word layout: [21]=eoe, [20]=tot, [19:12]=discr, [11:0]=adc
    localparam int EOE_BIT = 21;

    localparam logic [7:0] HDR_MARK = 8'hA5;
    localparam logic [7:0] TRL_MARK = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR0    = 3'd1,
        ST_HDR1    = 3'd2,
        ST_HDR2    = 3'd3,
        ST_DATA    = 3'd4,
        ST_TRAILER = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // Trailer: marker, overrun flag, 7 zero bits, accepted-sample count.
    function automatic logic [31:0] trailer_word(input logic err, input logic [15:0] cnt);
        return {TRL_MARK, err, 7'b0, cnt};
    endfunction

endpackage

// File: rtl/wvb_rd_skid.sv
// ---------------------------------------------------------------------------
// wvb_rd_skid
// Two-entry registered skid FIFO. The producer must not push while full; it
// uses free_cnt (slots not occupied) to pace itself, counting its own
// in-flight requests.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_data     write side (one word per asserted cycle)
//   free_cnt              number of empty slots (0..2)
//   out_valid, out_data   head of FIFO, stable until popped
//   out_ready             pop when out_valid && out_ready
// ---------------------------------------------------------------------------
module wvb_rd_skid #(
    parameter int P_WIDTH = 22
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [P_WIDTH-1:0] in_data,
    output logic [1:0]         free_cnt,
    output logic               out_valid,
    output logic [P_WIDTH-1:0] out_data,
    input  logic               out_ready
);

    logic [P_WIDTH-1:0] head_q, head_d;
    logic [P_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               pop;

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = head_q;
    assign free_cnt  = 2'd2 - cnt_q;
    assign pop       = out_valid && out_ready;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        unique case ({in_valid, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = in_data;
                    cnt_d  = 2'd1;
                end else if (cnt_q == 2'd1) begin
                    tail_d = in_data;
                    cnt_d  = 2'd2;
                end
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push/pop: occupancy unchanged, queue shifts.
                if (cnt_q == 2'd1) begin
                    head_d = in_data;
                end else begin
                    head_d = tail_q;
                    tail_d = in_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/wvb_reader.sv
// ---------------------------------------------------------------------------
// wvb_reader
// Drains completed waveforms from the waveform buffer and re-frames each as a
// 32-bit stream: three header words, one word per sample, one trailer word.
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   en                        allow starting new events
//   hdr_empty/hdr_data        FWFT header FIFO; hdr_rdreq pops it
//   wvb_data/wvb_rdreq        sample read port, data 1 clk after request
//   wvb_rddone                1-cycle pulse after an event's trailer
//   out_data/valid/last/ready framed output stream
//   busy                      not idle
//   err_overrun               sticky: an event hit the sample limit w/o eoe
//   evt_count                 completed events (wrapping)
// ---------------------------------------------------------------------------
module wvb_reader
    import wvb_reader_pkg::*;
#(
    parameter int P_DATA_WIDTH  = 22,
    parameter int P_HDR_WIDTH   = 80,
    parameter int P_MAX_SAMPLES = 4096,
    parameter int P_CNT_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    hdr_empty,
    input  logic [P_HDR_WIDTH-1:0]  hdr_data,
    output logic                    hdr_rdreq,
    input  logic [P_DATA_WIDTH-1:0] wvb_data,
    output logic                    wvb_rdreq,
    output logic                    wvb_rddone,
    output logic [31:0]             out_data,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    err_overrun,
    output logic [P_CNT_WIDTH-1:0]  evt_count
);

    localparam int RDW = $clog2(P_MAX_SAMPLES + 1);
    localparam logic [RDW-1:0]         RD_MAX  = RDW'(P_MAX_SAMPLES);
    localparam logic [RDW-1:0]         RD_ONE  = RDW'(1);
    localparam logic [P_CNT_WIDTH-1:0] CNT_ONE = P_CNT_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [P_HDR_WIDTH-1:0]  hdr_q;
    logic                    inflight_q;
    logic [RDW-1:0]          rd_cnt_q;
    logic                    rd_done_q;
    logic                    evt_err_q;
    logic                    err_overrun_q;
    logic [P_CNT_WIDTH-1:0]  smp_cnt_q;
    logic [P_CNT_WIDTH-1:0]  evt_count_q;

    logic                    start;
    logic                    hdr_load;
    logic                    ret_last;
    logic                    overrun_hit;
    logic                    rd_issue;
    logic                    smp_acc;
    logic                    skid_ready;
    logic [1:0]              skid_free;
    logic                    skid_valid;
    logic [P_DATA_WIDTH-1:0] skid_data;

    assign start = en && !hdr_empty;

    // A returning word ends the read phase if it carries eoe or is the
    // last read allowed for this event.
    assign ret_last    = inflight_q && (wvb_data[EOE_BIT] || (rd_cnt_q == RD_MAX));
    assign overrun_hit = inflight_q && !wvb_data[EOE_BIT] && (rd_cnt_q == RD_MAX);

    // Issue only while the skid can hold the in-flight word plus this one.
    // The returning word is inspected combinationally so no read is ever
    // issued past the end-of-event sample.
    assign rd_issue = (state_q == ST_DATA) && !rd_done_q && !ret_last
                      && (rd_cnt_q != RD_MAX) && (skid_free > {1'b0, inflight_q});

    assign smp_acc = (state_q == ST_DATA) && skid_valid && out_ready;

    wvb_rd_skid #(.P_WIDTH(P_DATA_WIDTH)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inflight_q),
        .in_data   (wvb_data),
        .free_cnt  (skid_free),
        .out_valid (skid_valid),
        .out_data  (skid_data),
        .out_ready (skid_ready)
    );

    always_comb begin
        state_d    = state_q;
        hdr_load   = 1'b0;
        hdr_rdreq  = 1'b0;
        wvb_rdreq  = 1'b0;
        wvb_rddone = 1'b0;
        out_data   = 32'h0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        skid_ready = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    hdr_load = 1'b1;
                    state_d  = ST_HDR0;
                end
            end
            ST_HDR0: begin
                out_valid = 1'b1;
                out_data  = {HDR_MARK, 8'h00, hdr_q[P_HDR_WIDTH-1 -: 16]};
                if (out_ready) state_d = ST_HDR1;
            end
            ST_HDR1: begin
                out_valid = 1'b1;
                out_data  = hdr_q[63:32];
                if (out_ready) state_d = ST_HDR2;
            end
            ST_HDR2: begin
                out_valid = 1'b1;
                out_data  = hdr_q[31:0];
                if (out_ready) begin
                    hdr_rdreq = 1'b1;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                out_valid  = skid_valid;
                out_data   = 32'(skid_data);
                skid_ready = out_ready;
                wvb_rdreq  = rd_issue;
                if (rd_done_q && !inflight_q && !skid_valid) state_d = ST_TRAILER;
            end
            ST_TRAILER: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = trailer_word(evt_err_q, 16'(smp_cnt_q));
                if (out_ready) state_d = ST_DONE;
            end
            ST_DONE: begin
                wvb_rddone = 1'b1;
                // Chain straight into the next event to lose only this cycle.
                if (start) begin
                    hdr_load = 1'b1;
                    state_d  = ST_HDR0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            hdr_q         <= '0;
            inflight_q    <= 1'b0;
            rd_cnt_q      <= '0;
            rd_done_q     <= 1'b0;
            evt_err_q     <= 1'b0;
            err_overrun_q <= 1'b0;
            smp_cnt_q     <= '0;
            evt_count_q   <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= rd_issue;
            if (hdr_load) begin
                hdr_q     <= hdr_data;
                rd_cnt_q  <= '0;
                rd_done_q <= 1'b0;
                evt_err_q <= 1'b0;
                smp_cnt_q <= '0;
            end else begin
                if (rd_issue)    rd_cnt_q  <= rd_cnt_q + RD_ONE;
                if (ret_last)    rd_done_q <= 1'b1;
                if (overrun_hit) evt_err_q <= 1'b1;
                if (smp_acc && (smp_cnt_q != '1)) smp_cnt_q <= smp_cnt_q + CNT_ONE;
            end
            if (overrun_hit)         err_overrun_q <= 1'b1;
            if (state_q == ST_DONE)  evt_count_q   <= evt_count_q + CNT_ONE;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign err_overrun = err_overrun_q;
    assign evt_count   = evt_count_q;

endmodule
